// File: rtl/pipe_mem_wb_stage.sv
// MEM/WB pipeline register with stall/flush control, register-file write port
// and saturating retire/load/store/I-O counters for board debug display.
module pipe_mem_wb_stage #(
    parameter int CNT_W  = 16,
    parameter int IO_BIT = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             mvalid,
    input  logic             mwreg,
    input  logic             mm2reg,
    input  logic             mwmem,
    input  logic [4:0]       mrn,
    input  logic [31:0]      maddr,
    input  logic [31:0]      mmo,
    input  logic             stall,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic             wvalid,
    output logic             wwreg,
    output logic             wm2reg,
    output logic [4:0]       wrn,
    output logic [31:0]      walu,
    output logic [31:0]      wmo,
    output logic [31:0]      wdi,
    output logic             rf_we,
    output logic [31:0]      retired,
    output logic [CNT_W-1:0] loads,
    output logic [CNT_W-1:0] stores,
    output logic [CNT_W-1:0] io_acc
);

    logic             wvalid_q, wvalid_d;
    logic             wwreg_q, wwreg_d;
    logic             wm2reg_q, wm2reg_d;
    logic [4:0]       wrn_q, wrn_d;
    logic [31:0]      walu_q, walu_d;
    logic [31:0]      wmo_q, wmo_d;
    logic [31:0]      retired_q, retired_d;
    logic [CNT_W-1:0] loads_q, loads_d;
    logic [CNT_W-1:0] stores_q, stores_d;
    logic [CNT_W-1:0] io_acc_q, io_acc_d;
    logic             enter;
    logic             is_io;

    assign enter = mvalid & ~flush & ~stall;
    assign is_io = (mm2reg | mwmem) & maddr[IO_BIT];

    always_comb begin
        wvalid_d = wvalid_q;
        wwreg_d  = wwreg_q;
        wm2reg_d = wm2reg_q;
        wrn_d    = wrn_q;
        walu_d   = walu_q;
        wmo_d    = wmo_q;
        if (flush) begin
            wvalid_d = 1'b0;
            wwreg_d  = 1'b0;
            wm2reg_d = 1'b0;
            wrn_d    = 5'd0;
            walu_d   = maddr;
            wmo_d    = mmo;
        end else if (!stall) begin
            wvalid_d = mvalid;
            wwreg_d  = mwreg & mvalid;
            wm2reg_d = mm2reg & mvalid;
            wrn_d    = mrn;
            walu_d   = maddr;
            wmo_d    = mmo;
        end
    end

    // Counters stick at all-ones; clear beats a same-cycle increment
    always_comb begin
        retired_d = retired_q;
        loads_d   = loads_q;
        stores_d  = stores_q;
        io_acc_d  = io_acc_q;
        if (cnt_clr) begin
            retired_d = 32'd0;
            loads_d   = '0;
            stores_d  = '0;
            io_acc_d  = '0;
        end else if (enter) begin
            if (retired_q != '1)
                retired_d = retired_q + 32'd1;
            if (mm2reg && loads_q != '1)
                loads_d = loads_q + CNT_W'(1);
            if (mwmem && stores_q != '1)
                stores_d = stores_q + CNT_W'(1);
            if (is_io && io_acc_q != '1)
                io_acc_d = io_acc_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wvalid_q  <= 1'b0;
            wwreg_q   <= 1'b0;
            wm2reg_q  <= 1'b0;
            wrn_q     <= 5'd0;
            walu_q    <= 32'd0;
            wmo_q     <= 32'd0;
            retired_q <= 32'd0;
            loads_q   <= '0;
            stores_q  <= '0;
            io_acc_q  <= '0;
        end else begin
            wvalid_q  <= wvalid_d;
            wwreg_q   <= wwreg_d;
            wm2reg_q  <= wm2reg_d;
            wrn_q     <= wrn_d;
            walu_q    <= walu_d;
            wmo_q     <= wmo_d;
            retired_q <= retired_d;
            loads_q   <= loads_d;
            stores_q  <= stores_d;
            io_acc_q  <= io_acc_d;
        end
    end

    assign wvalid  = wvalid_q;
    assign wwreg   = wwreg_q;
    assign wm2reg  = wm2reg_q;
    assign wrn     = wrn_q;
    assign walu    = walu_q;
    assign wmo     = wmo_q;
    assign wdi     = wm2reg_q ? wmo_q : walu_q;
    assign rf_we   = wvalid_q & wwreg_q & (wrn_q != 5'd0);
    assign retired = retired_q;
    assign loads   = loads_q;
    assign stores  = stores_q;
    assign io_acc  = io_acc_q;

endmodule

// File: tb/tb_pipe_mem_wb_stage.sv
// Directed bench for pipe_mem_wb_stage: a default-width instance plus a
// 4-bit-counter instance sharing the same stimulus for saturation checks.
module tb_pipe_mem_wb_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        mvalid, mwreg, mm2reg, mwmem;
    logic [4:0]  mrn;
    logic [31:0] maddr, mmo;
    logic        stall, flush, cnt_clr;

    logic        wvalid, wwreg, wm2reg, rf_we;
    logic [4:0]  wrn;
    logic [31:0] walu, wmo, wdi, retired;
    logic [15:0] loads, stores, io_acc;

    logic        s_wvalid, s_wwreg, s_wm2reg, s_rf_we;
    logic [4:0]  s_wrn;
    logic [31:0] s_walu, s_wmo, s_wdi, s_retired;
    logic [3:0]  s_loads, s_stores, s_io_acc;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    pipe_mem_wb_stage u_dut (
        .clock(clock), .reset(reset), .mvalid(mvalid), .mwreg(mwreg),
        .mm2reg(mm2reg), .mwmem(mwmem), .mrn(mrn), .maddr(maddr),
        .mmo(mmo), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .wvalid(wvalid), .wwreg(wwreg), .wm2reg(wm2reg), .wrn(wrn),
        .walu(walu), .wmo(wmo), .wdi(wdi), .rf_we(rf_we),
        .retired(retired), .loads(loads), .stores(stores), .io_acc(io_acc)
    );

    pipe_mem_wb_stage #(.CNT_W(4)) u_sat (
        .clock(clock), .reset(reset), .mvalid(mvalid), .mwreg(mwreg),
        .mm2reg(mm2reg), .mwmem(mwmem), .mrn(mrn), .maddr(maddr),
        .mmo(mmo), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
        .wvalid(s_wvalid), .wwreg(s_wwreg), .wm2reg(s_wm2reg), .wrn(s_wrn),
        .walu(s_walu), .wmo(s_wmo), .wdi(s_wdi), .rf_we(s_rf_we),
        .retired(s_retired), .loads(s_loads), .stores(s_stores),
        .io_acc(s_io_acc)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic bubble();
        mvalid = 0; mwreg = 0; mm2reg = 0; mwmem = 0;
        mrn = 0; maddr = 0; mmo = 0;
    endtask

    task automatic instr(input logic wr, input logic ld, input logic st,
                         input logic [4:0] rn, input logic [31:0] a,
                         input logic [31:0] d);
        mvalid = 1; mwreg = wr; mm2reg = ld; mwmem = st;
        mrn = rn; maddr = a; mmo = d;
    endtask

    initial begin
        reset = 1; stall = 0; flush = 0; cnt_clr = 0;
        bubble();
        step();
        step();
        chk("rst_wvalid", wvalid, 0);
        chk("rst_wdi", wdi, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_retired", retired, 0);
        reset = 0;

        // five ALU ops, then asynchronous reset between edges
        for (int i = 1; i <= 5; i++) begin
            instr(1, 0, 0, 5'(i), 32'(i * 16), 0);
            step();
        end
        chk("pre_rst_retired", retired, 5);
        chk("pre_rst_wdi", wdi, 32'h50);
        bubble();
        #2 reset = 1;
        #1;
        chk("async_retired", retired, 0);
        chk("async_wvalid", wvalid, 0);
        chk("async_wdi", wdi, 0);
        chk("async_rf_we", rf_we, 0);
        chk("async_wrn", wrn, 0);
        #1 reset = 0;
        step();

        // load
        instr(1, 1, 0, 3, 32'h14, 32'hDEADBEEF);
        step();
        chk("ld_wdi", wdi, 32'hDEADBEEF);
        chk("ld_rf_we", rf_we, 1);
        chk("ld_wrn", wrn, 3);
        chk("ld_loads", loads, 1);
        chk("ld_retired", retired, 1);
        chk("ld_io", io_acc, 0);

        // I/O store
        instr(0, 0, 1, 7, 32'h80, 32'h0);
        step();
        chk("st_stores", stores, 1);
        chk("st_io", io_acc, 1);
        chk("st_rf_we", rf_we, 0);
        chk("st_retired", retired, 2);
        chk("st_walu", walu, 32'h80);

        // stall three cycles with a different load waiting
        instr(1, 1, 0, 9, 32'h123, 32'h55);
        stall = 1;
        for (int i = 0; i < 3; i++) step();
        chk("stall_walu", walu, 32'h80);
        chk("stall_wvalid", wvalid, 1);
        chk("stall_wrn", wrn, 7);
        chk("stall_retired", retired, 2);
        chk("stall_loads", loads, 1);

        // flush with stall
        flush = 1;
        step();
        chk("fs_wvalid", wvalid, 0);
        chk("fs_wrn", wrn, 0);
        chk("fs_rf_we", rf_we, 0);
        chk("fs_retired", retired, 2);
        stall = 0;

        // flush alone
        step();
        chk("fl_wm2reg", wm2reg, 0);
        chk("fl_wvalid", wvalid, 0);
        chk("fl_loads", loads, 1);
        flush = 0;

        // r0 write
        instr(1, 0, 0, 0, 32'h7, 32'h0);
        step();
        chk("r0_wdi", wdi, 32'h7);
        chk("r0_rf_we", rf_we, 0);
        chk("r0_wwreg", wwreg, 1);
        chk("r0_retired", retired, 3);

        // 17 non-I/O loads saturate the 4-bit instance
        for (int i = 0; i < 17; i++) begin
            instr(1, 1, 0, 2, 32'h100, 32'(i));
            step();
        end
        chk("sat_loads4", s_loads, 15);
        chk("sat_loads16", loads, 18);
        chk("sat_retired", retired, 20);
        chk("sat_io", io_acc, 1);
        chk("sat_wdi", wdi, 16);

        // clear beats a concurrent load; pipeline still captures
        instr(1, 1, 0, 4, 32'h8, 32'hCAFE);
        cnt_clr = 1;
        step();
        cnt_clr = 0;
        chk("clr_loads4", s_loads, 0);
        chk("clr_loads16", loads, 0);
        chk("clr_retired", retired, 0);
        chk("clr_stores", stores, 0);
        chk("clr_wdi", wdi, 32'hCAFE);
        chk("clr_rf_we", rf_we, 1);

        step();
        chk("post_clr_loads", loads, 1);
        bubble();
        step();
        chk("bubble_wvalid", wvalid, 0);
        chk("bubble_retired", retired, 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
